// File: rtl/fpmul_pkg.sv
// Shared constants, types and helpers for the APB single-precision multiplier.
package fpmul_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned XEXP_W = 10;
  localparam int unsigned ST_W   = 6;
  localparam int unsigned OFF_W  = 3;

  localparam logic [XEXP_W-1:0] BIAS = 10'd127;

  // Word offsets (paddr[4:2])
  localparam logic [OFF_W-1:0] OFF_OPA  = 3'd0;
  localparam logic [OFF_W-1:0] OFF_OPB  = 3'd1;
  localparam logic [OFF_W-1:0] OFF_CTRL = 3'd2;
  localparam logic [OFF_W-1:0] OFF_STAT = 3'd3;
  localparam logic [OFF_W-1:0] OFF_RES  = 3'd4;

  // STATUS bit positions
  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVF  = 2;
  localparam int unsigned ST_UNF  = 3;
  localparam int unsigned ST_INV  = 4;
  localparam int unsigned ST_INX  = 5;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MUL, S_NORM, S_PACK
  } fsm_state_e;

  typedef enum logic [1:0] {
    CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN
  } op_class_e;

  // Subnormals are flushed to zero on input.
  function automatic op_class_e classify(input fp32_t f);
    if (f.exp == '0)      return CLS_ZERO;
    else if (&f.exp)      return (f.man == '0) ? CLS_INF : CLS_NAN;
    else                  return CLS_NUM;
  endfunction

endpackage

// File: rtl/fpmul_core.sv
// Iterative single-precision multiplier: fixed-latency FSM, shift-add mantissa, RNE rounding.
module fpmul_core
  import fpmul_pkg::*;
#(
  parameter int unsigned MUL_CYC = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  fp32_t           op_a_i,
  input  fp32_t           op_b_i,
  output logic [ST_W-1:0] status_o,
  output logic [31:0]     result_o
);

  localparam int unsigned CNT_W = $clog2(MUL_CYC);
  localparam int unsigned LEAD  = PROD_W - 2;
  localparam int unsigned SUM_W = SIG_W + 1;

  fsm_state_e               state_q;
  op_class_e                class_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sign_q;
  logic signed [XEXP_W-1:0] exp_q;
  logic [PROD_W-1:0]        mcand_q;
  logic [SIG_W-1:0]         mplier_q;
  logic [PROD_W-1:0]        prod_q;
  logic                     sticky_q;
  logic                     busy_q, done_q, ovf_q, unf_q, inv_q, inx_q;
  logic [31:0]              result_q;

  op_class_e                cls_a_c, cls_b_c, cls_c;
  logic [SIG_W-1:0]         man_c;
  logic                     g_c, r_c, s_c, rnd_up_c;
  logic [SUM_W-1:0]         sum_c;
  logic [MAN_W-1:0]         frac_c;
  logic signed [XEXP_W-1:0] exp_rnd_c;
  logic [31:0]              res_c;
  logic                     ovf_c, unf_c, inv_c, inx_c;

  // Operand classification; NaN and inf*0 dominate, then inf, then zero.
  always_comb begin
    cls_a_c = classify(op_a_i);
    cls_b_c = classify(op_b_i);
    cls_c   = CLS_NUM;
    if (cls_a_c == CLS_NAN || cls_b_c == CLS_NAN ||
        (cls_a_c == CLS_INF && cls_b_c == CLS_ZERO) ||
        (cls_a_c == CLS_ZERO && cls_b_c == CLS_INF))
      cls_c = CLS_NAN;
    else if (cls_a_c == CLS_INF || cls_b_c == CLS_INF)
      cls_c = CLS_INF;
    else if (cls_a_c == CLS_ZERO || cls_b_c == CLS_ZERO)
      cls_c = CLS_ZERO;
  end

  // Round-to-nearest-even on the normalised product, then range check and packing.
  always_comb begin
    man_c     = prod_q[LEAD -: SIG_W];
    g_c       = prod_q[LEAD-SIG_W];
    r_c       = prod_q[LEAD-SIG_W-1];
    s_c       = (|prod_q[LEAD-SIG_W-2:0]) | sticky_q;
    rnd_up_c  = g_c & (r_c | s_c | man_c[0]);
    sum_c     = {1'b0, man_c} + SUM_W'(rnd_up_c);
    frac_c    = sum_c[SIG_W] ? sum_c[MAN_W:1] : sum_c[MAN_W-1:0];
    exp_rnd_c = exp_q + XEXP_W'(sum_c[SIG_W]);
    res_c     = '0;
    ovf_c     = 1'b0;
    unf_c     = 1'b0;
    inv_c     = 1'b0;
    inx_c     = 1'b0;
    case (class_q)
      CLS_NAN: begin
        res_c = QNAN;
        inv_c = 1'b1;
      end
      CLS_INF:  res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: res_c = {sign_q, 31'd0};
      default: begin
        if (exp_rnd_c >= 10'sd255) begin
          res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_c = 1'b1;
          inx_c = 1'b1;
        end else if (exp_rnd_c <= 10'sd0) begin
          res_c = {sign_q, 31'd0};
          unf_c = 1'b1;
          inx_c = g_c | r_c | s_c;
        end else begin
          res_c = {sign_q, exp_rnd_c[EXP_W-1:0], frac_c};
          inx_c = g_c | r_c | s_c;
        end
      end
    endcase
  end

  // Sequencer and datapath registers: IDLE -> UNPACK -> MUL x MUL_CYC -> NORM -> PACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      class_q  <= CLS_NUM;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= 1'b0;
            inx_q   <= 1'b0;
            state_q <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          class_q  <= cls_c;
          sign_q   <= op_a_i.sign ^ op_b_i.sign;
          exp_q    <= XEXP_W'(op_a_i.exp) + XEXP_W'(op_b_i.exp) - BIAS;
          mcand_q  <= PROD_W'({1'b1, op_a_i.man});
          mplier_q <= {1'b1, op_b_i.man};
          prod_q   <= '0;
          sticky_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_MUL;
        end
        S_MUL: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CNT_W'(MUL_CYC - 1)) state_q <= S_NORM;
          else                              cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_NORM: begin
          if (prod_q[PROD_W-1]) begin
            prod_q   <= prod_q >> 1;
            sticky_q <= prod_q[0];
            exp_q    <= exp_q + 10'sd1;
          end
          state_q <= S_PACK;
        end
        S_PACK: begin
          result_q <= res_c;
          ovf_q    <= ovf_c;
          unf_q    <= unf_c;
          inv_q    <= inv_c;
          inx_q    <= inx_c;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign status_o = {inx_q, inv_q, unf_q, ovf_q, done_q, busy_q};
  assign result_o = result_q;

endmodule

// File: rtl/fpmul_apb_slave.sv
// APB slave front-end for fpmul_core: register decode, operand registers, readback.
// Build option FPMUL_AUTOSTART_EN: an accepted OP_B write also starts an operation.
module fpmul_apb_slave
  import fpmul_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 27
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic              pready,
  output logic [31:0]       prdata
);

  fp32_t            op_a_q, op_b_q;
  logic [31:0]      prdata_q;
  logic [ST_W-1:0]  status_c;
  logic [31:0]      result_c;
  logic [OFF_W-1:0] off_c;
  logic             wr_ok_c, rd_setup_c, start_c;
  logic [31:0]      rdata_c;
  logic             unused_addr_c;

  assign off_c         = paddr[4:2];
  assign unused_addr_c = ^{paddr[ADDR_W-1:5], paddr[1:0]};
  assign wr_ok_c       = psel & penable & pwrite & ~status_c[ST_BUSY];
  assign rd_setup_c    = psel & ~penable & ~pwrite;

`ifdef FPMUL_AUTOSTART_EN
  assign start_c = wr_ok_c & (((off_c == OFF_CTRL) & pwdata[0]) | (off_c == OFF_OPB));
`else
  assign start_c = wr_ok_c & (off_c == OFF_CTRL) & pwdata[0];
`endif

  // Readback mux; CTRL and unmapped offsets read as zero.
  always_comb begin
    rdata_c = '0;
    case (off_c)
      OFF_OPA:  rdata_c = op_a_q;
      OFF_OPB:  rdata_c = op_b_q;
      OFF_STAT: rdata_c = 32'(status_c);
      OFF_RES:  rdata_c = result_c;
      default:  rdata_c = '0;
    endcase
  end

  // Operand writes (blocked while busy) and setup-phase read capture.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      prdata_q <= '0;
    end else begin
      if (wr_ok_c && off_c == OFF_OPA) op_a_q <= fp32_t'(pwdata);
      if (wr_ok_c && off_c == OFF_OPB) op_b_q <= fp32_t'(pwdata);
      if (rd_setup_c)                  prdata_q <= rdata_c;
    end
  end

  fpmul_core #(
    .MUL_CYC (LATENCY - 3)
  ) u_core (
    .clk      (pclk),
    .rst_n    (presetn),
    .start_i  (start_c),
    .op_a_i   (op_a_q),
    .op_b_i   (op_b_q),
    .status_o (status_c),
    .result_o (result_c)
  );

  assign pready = 1'b1;
  assign prdata = prdata_q;

endmodule

// File: tb/tb_fpmul_apb_slave.sv
// Scoreboard bench for fpmul_apb_slave; honours FPMUL_AUTOSTART_EN when defined.
module tb_fpmul_apb_slave;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LATENCY = 27;
  localparam int unsigned N_CASES = 12;

  localparam logic [31:0] A_OPA  = 32'h00;
  localparam logic [31:0] A_OPB  = 32'h04;
  localparam logic [31:0] A_CTRL = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_RES  = 32'h10;

  logic              pclk    = 1'b0;
  logic              presetn = 1'b0;
  logic [ADDR_W-1:0] paddr   = '0;
  logic              psel    = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite  = 1'b0;
  logic [31:0]       pwdata  = '0;
  logic              pready;
  logic [31:0]       prdata;

  fpmul_apb_slave #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pready  (pready),
    .prdata  (prdata)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] st;
  } exp_t;
  exp_t sb_q[$];

  // Operand A, operand B, expected RESULT, expected STATUS
  logic [31:0] tbl_a [N_CASES] = '{32'hC0000000, 32'h7F800000, 32'h7F7FFFFF, 32'h00800000,
                                   32'h3F800001, 32'h3FC00001, 32'h3FFFFFFF, 32'hFF800000,
                                   32'h7FC00001, 32'h80000000, 32'h00000001, 32'h00000000};
  logic [31:0] tbl_b [N_CASES] = '{32'h3F000000, 32'h00000000, 32'h40000000, 32'h3F000000,
                                   32'h3F800001, 32'h3FC00001, 32'h3FFFFFFF, 32'h40000000,
                                   32'h3F800000, 32'h40000000, 32'hC0000000, 32'hFF800000};
  logic [31:0] tbl_r [N_CASES] = '{32'hBF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                                   32'h3F800002, 32'h40100002, 32'h407FFFFE, 32'hFF800000,
                                   32'h7FC00000, 32'h80000000, 32'h80000000, 32'h7FC00000};
  logic [31:0] tbl_s [N_CASES] = '{32'h02, 32'h12, 32'h26, 32'h0A,
                                   32'h22, 32'h22, 32'h22, 32'h02,
                                   32'h12, 32'h02, 32'h02, 32'h12};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called just after a clock edge; write lands on the second edge.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    paddr = addr; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Called just after a clock edge; prdata is captured on the first edge.
  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    data = prdata;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Read STATUS captured on edge start_cyc + k.
  task automatic read_at(input int k, output logic [31:0] data);
    int target;
    target = start_cyc + k - 1;
    if (cyc > target) check_eq("read_at_late", cyc, target);
    while (cyc < target) begin
      @(posedge pclk); #1;
    end
    apb_read(A_STAT, data);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic [31:0] st);
    apb_write(A_OPA, a);
    apb_write(A_OPB, b);
`ifdef FPMUL_AUTOSTART_EN
    start_cyc = cyc;
`endif
    apb_write(A_CTRL, 32'h1);
`ifndef FPMUL_AUTOSTART_EN
    start_cyc = cyc;
`endif
    sb_q.push_back({res, st});
  endtask

  // Poll for done (bounded), then compare STATUS and RESULT against the scoreboard.
  task automatic finish_op(input string tag);
    logic [31:0] st;
    logic [31:0] res;
    exp_t        e;
    st = '0;
    for (int i = 0; i < 40 && !st[1]; i++) apb_read(A_STAT, st);
    e = sb_q.pop_front();
    check_eq({tag, "_status"}, st, e.st);
    apb_read(A_RES, res);
    check_eq({tag, "_result"}, res, e.res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    repeat (3) @(posedge pclk);
    #1;
    check_eq("rst_prdata", prdata, 32'h0);
    presetn = 1'b1;
    @(posedge pclk); #1;
    check_eq("pready", 32'(pready), 32'h1);
    apb_read(A_OPA, r);  check_eq("rst_opa", r, 32'h0);
    apb_read(A_OPB, r);  check_eq("rst_opb", r, 32'h0);
    apb_read(A_STAT, r); check_eq("rst_status", r, 32'h0);
    apb_read(A_RES, r);  check_eq("rst_result", r, 32'h0);

    // 2.0 * 3.0 with busy window checks
    start_op(32'h40000000, 32'h40400000, 32'h40C00000, 32'h02);
    read_at(1, r);  check_eq("busy_first", r, 32'h01);
    read_at(27, r); check_eq("busy_last", r, 32'h01);
    finish_op("mul_2x3");

    // 1.5 * 1.5: done visible exactly after edge 27
    start_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h02);
    read_at(28, r); check_eq("done_at_27", r, 32'h02);
    finish_op("mul_1p5sq");
    apb_read(A_STAT, r); check_eq("done_sticky", r, 32'h02);

    apb_read(A_CTRL, r);  check_eq("ctrl_reads0", r, 32'h0);
    apb_read(32'h14, r);  check_eq("unmapped_rd", r, 32'h0);

    for (int i = 0; i < N_CASES; i++) begin
      start_op(tbl_a[i], tbl_b[i], tbl_r[i], tbl_s[i]);
      finish_op($sformatf("case%0d", i));
    end

    // Writes and a restart while busy are ignored
    start_op(32'h40000000, 32'h40400000, 32'h40C00000, 32'h02);
    while (cyc < start_cyc + 3) begin
      @(posedge pclk); #1;
    end
    apb_write(A_OPA, 32'h3F800000);
    apb_write(A_CTRL, 32'h1);
    read_at(28, r); check_eq("busy_ignore_done", r, 32'h02);
    finish_op("busy_ignore");
    apb_read(A_OPA, r); check_eq("busy_ignore_opa", r, 32'h40000000);

    // Reset in the middle of an operation
    apb_write(A_OPA, 32'h3FC00000);
    apb_write(A_OPB, 32'h3FC00000);
    apb_write(A_CTRL, 32'h1);
    start_cyc = cyc;
    while (cyc < start_cyc + 10) begin
      @(posedge pclk); #1;
    end
    presetn = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check_eq("midrst_prdata", prdata, 32'h0);
    presetn = 1'b1;
    @(posedge pclk); #1;
    apb_read(A_OPA, r);  check_eq("midrst_opa", r, 32'h0);
    apb_read(A_OPB, r);  check_eq("midrst_opb", r, 32'h0);
    apb_read(A_STAT, r); check_eq("midrst_status", r, 32'h0);
    apb_read(A_RES, r);  check_eq("midrst_result", r, 32'h0);
    repeat (30) @(posedge pclk);
    #1;
    apb_read(A_STAT, r); check_eq("midrst_discarded", r, 32'h0);

    start_op(32'hC0000000, 32'h3F000000, 32'hBF800000, 32'h02);
    finish_op("post_reset");

`ifdef FPMUL_AUTOSTART_EN
    apb_write(A_OPB, 32'h40000000);
    start_cyc = cyc;
    sb_q.push_back({32'hC0800000, 32'h02});
    read_at(27, r); check_eq("auto_busy", r, 32'h01);
    read_at(29, r); check_eq("auto_done", r, 32'h02);
    finish_op("autostart");
`else
    apb_write(A_OPB, 32'h40000000);
    apb_read(A_STAT, r); check_eq("opb_no_start", r, 32'h02);
    apb_read(A_RES, r);  check_eq("opb_no_start_res", r, 32'hBF800000);
`endif

    check_eq("sb_empty", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
